// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx : PS/2 device-to-host receiver with clock glitch filter and timeout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] code,
  output logic        signal,
  output logic        err
);

  localparam logic [7:0]  FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [15:0] TO_MAX    = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t      state, state_next;
  logic        clk_meta, clk_sync, data_meta, data_sync;
  logic        clk_filt, clk_prev;
  logic [7:0]  filt_cnt;
  logic [15:0] to_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_byte;
  logic        par_bit;
  logic        fall, timeout, parity_ok;
  logic        load_code, frame_err, shift, store_par, clr_frame;

  // Synchronizers reset high to match the idle state of the lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      clk_prev <= 1'b1;
      filt_cnt <= 8'd0;
    end else begin
      clk_prev <= clk_filt;
      if (clk_sync == clk_filt) begin
        filt_cnt <= 8'd0;
      end else if (filt_cnt == FILT_LAST) begin
        clk_filt <= clk_sync;
        filt_cnt <= 8'd0;
      end else begin
        filt_cnt <= filt_cnt + 8'd1;
      end
    end
  end

  assign fall      = clk_prev & ~clk_filt;
  assign timeout   = (state != IDLE) && (to_cnt == TO_MAX);
  assign parity_ok = ^{rx_byte, par_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= 16'd0;
    end else if (state == IDLE || fall) begin
      to_cnt <= 16'd0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Timeout overrides any edge arriving in the same cycle
  always_comb begin
    state_next = state;
    load_code  = 1'b0;
    frame_err  = 1'b0;
    shift      = 1'b0;
    store_par  = 1'b0;
    clr_frame  = 1'b0;
    if (timeout) begin
      state_next = IDLE;
      frame_err  = 1'b1;
      clr_frame  = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!data_sync) begin
            state_next = DATA;
            clr_frame  = 1'b1;
          end
        end
        DATA: begin
          shift = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          store_par  = 1'b1;
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (data_sync && parity_ok) begin
            load_code = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 3'd0;
      rx_byte <= 8'd0;
      par_bit <= 1'b0;
      code    <= 16'h0000;
      signal  <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (clr_frame) begin
        bit_cnt <= 3'd0;
        rx_byte <= 8'd0;
      end else if (shift) begin
        rx_byte <= {data_sync, rx_byte[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (store_par) begin
        par_bit <= data_sync;
      end
      if (load_code) begin
        code <= {code[7:0], rx_byte};
      end
      signal <= load_code;
      err    <= frame_err;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx : directed self-checking bench for ps2_rx
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ps2_rx;

  localparam int FL   = 8;
  localparam int TO   = 400;
  localparam int HALF = 60;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] code;
  logic        signal;
  logic        err;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .code     (code),
    .signal   (signal),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          sig_cnt  = 0;
  int          err_cnt  = 0;
  int          both_cnt = 0;
  logic [15:0] sig_code = 16'h0;
  longint      cyc      = 0;
  longint      err_cyc  = 0;
  longint      fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (signal) begin
        sig_cnt  <= sig_cnt + 1;
        sig_code <= code;
      end
      if (err) begin
        err_cnt <= err_cnt + 1;
        err_cyc <= cyc;
      end
      if (signal && err) both_cnt <= both_cnt + 1;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic p, input logic s);
    return {s, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk  = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
    send_bits(mk(b, p, s), 0, 10);
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic glitch_clk();
    ps2_clk = 1'b0;
    wait_cyc(FL - 1);
    ps2_clk = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    n_checks++;
    if (code !== 16'h0000) begin n_fail++; $display("FAIL reset_code got %h want 0000", code); end
    n_checks++;
    if (signal !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_outs got sig=%b err=%b want 0 0", signal, err); end
    rst_n = 1'b1;
    wait_cyc(5);
  endtask

  task automatic test_basic();
    int s0, e0;
    s0 = sig_cnt; e0 = err_cnt;
    send_frame(8'hF0, 1'b1, 1'b1);
    n_checks++;
    if (sig_cnt !== s0 + 1 || sig_code !== 16'h00F0) begin n_fail++; $display("FAIL basic_f0 got pulses=%0d code=%h want %0d 00F0", sig_cnt - s0, sig_code, 1); end
    send_frame(8'h16, 1'b0, 1'b1);
    n_checks++;
    if (sig_cnt !== s0 + 2 || code !== 16'hF016) begin n_fail++; $display("FAIL basic_16 got pulses=%0d code=%h want 2 F016", sig_cnt - s0, code); end
    n_checks++;
    if (err_cnt !== e0) begin n_fail++; $display("FAIL basic_err got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_parity_err();
    int s0, e0;
    s0 = sig_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    n_checks++;
    if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL parity_err got %0d want 1", err_cnt - e0); end
    n_checks++;
    if (sig_cnt !== s0 || code !== 16'hF016) begin n_fail++; $display("FAIL parity_code got pulses=%0d code=%h want 0 F016", sig_cnt - s0, code); end
  endtask

  task automatic test_stop_err();
    int s0, e0;
    s0 = sig_cnt; e0 = err_cnt;
    send_frame(8'h45, 1'b0, 1'b0);
    n_checks++;
    if (err_cnt !== e0 + 1 || sig_cnt !== s0 || code !== 16'hF016) begin n_fail++; $display("FAIL stop_err got err=%0d sig=%0d code=%h want 1 0 F016", err_cnt - e0, sig_cnt - s0, code); end
    send_frame(8'h45, 1'b0, 1'b1);
    n_checks++;
    if (sig_cnt !== s0 + 1 || code !== 16'h1645 || err_cnt !== e0 + 1) begin n_fail++; $display("FAIL stop_recover got sig=%0d code=%h err=%0d want 1 1645 1", sig_cnt - s0, code, err_cnt - e0); end
  endtask

  task automatic test_timeout();
    int s0, e0;
    longint delta;
    s0 = sig_cnt; e0 = err_cnt;
    send_bits(mk(8'h16, 1'b0, 1'b1), 0, 4);
    ps2_data = 1'b1;
    wait_cyc(TO + 100);
    delta = err_cyc - fall_cyc;
    n_checks++;
    if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL timeout_err got %0d want 1", err_cnt - e0); end
    n_checks++;
    if (delta < TO || delta > TO + FL + 10) begin n_fail++; $display("FAIL timeout_delay got %0d want %0d..%0d", delta, TO, TO + FL + 10); end
    send_frame(8'h16, 1'b0, 1'b1);
    n_checks++;
    if (sig_cnt !== s0 + 1 || code !== 16'h4516 || err_cnt !== e0 + 1) begin n_fail++; $display("FAIL timeout_recover got sig=%0d code=%h err=%0d want 1 4516 1", sig_cnt - s0, code, err_cnt - e0); end
  endtask

  task automatic test_glitch();
    int s0, e0;
    logic [10:0] f;
    s0 = sig_cnt; e0 = err_cnt;
    ps2_data = 1'b0;
    wait_cyc(10);
    glitch_clk();
    wait_cyc(20);
    ps2_data = 1'b1;
    wait_cyc(20);
    f = mk(8'h5A, 1'b1, 1'b1);
    send_bits(f, 0, 4);
    ps2_data = f[5];
    wait_cyc(10);
    glitch_clk();
    wait_cyc(10);
    send_bits(f, 5, 10);
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
    n_checks++;
    if (sig_cnt !== s0 + 1 || code !== 16'h165A) begin n_fail++; $display("FAIL glitch_code got sig=%0d code=%h want 1 165A", sig_cnt - s0, code); end
    n_checks++;
    if (err_cnt !== e0) begin n_fail++; $display("FAIL glitch_err got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_reset_midframe();
    int s0, e0;
    logic [10:0] f;
    s0 = sig_cnt; e0 = err_cnt;
    f = mk(8'h2B, 1'b1, 1'b1);
    send_bits(f, 0, 8);
    ps2_data = f[9];
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF / 2);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (code !== 16'h0000 || signal !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL midrst_async got code=%h sig=%b err=%b want 0000 0 0", code, signal, err); end
    wait_cyc(HALF / 2);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(20);
    rst_n = 1'b1;
    wait_cyc(20);
    n_checks++;
    if (sig_cnt !== s0 || err_cnt !== e0 || code !== 16'h0000) begin n_fail++; $display("FAIL midrst_quiet got sig=%0d err=%0d code=%h want 0 0 0000", sig_cnt - s0, err_cnt - e0, code); end
    send_frame(8'h2B, 1'b1, 1'b1);
    n_checks++;
    if (sig_cnt !== s0 + 1 || code !== 16'h002B) begin n_fail++; $display("FAIL midrst_frame got sig=%0d code=%h want 1 002B", sig_cnt - s0, code); end
  endtask

  task automatic test_back_to_back();
    int s0, e0;
    s0 = sig_cnt; e0 = err_cnt;
    send_frame(8'h45, 1'b0, 1'b1);
    n_checks++;
    if (sig_code !== 16'h2B45) begin n_fail++; $display("FAIL b2b_first got %h want 2B45", sig_code); end
    send_frame(8'h45, 1'b0, 1'b1);
    n_checks++;
    if (sig_cnt !== s0 + 2 || sig_code !== 16'h4545 || err_cnt !== e0) begin n_fail++; $display("FAIL b2b_second got sig=%0d code=%h err=%0d want 2 4545 0", sig_cnt - s0, sig_code, err_cnt - e0); end
    n_checks++;
    if (both_cnt !== 0) begin n_fail++; $display("FAIL sig_err_overlap got %0d want 0", both_cnt); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_stop_err();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
